// File: rtl/ika87ad_pkg.sv
// Shared constants for the opcode fetch front end and the opcode decoder:
// page numbers, prefix byte values and the fetch FSM state encoding.
package ika87ad_pkg;

    localparam logic [2:0] PG_MAIN = 3'd0;
    localparam logic [2:0] PG_48   = 3'd1;
    localparam logic [2:0] PG_60   = 3'd2;
    localparam logic [2:0] PG_64   = 3'd3;
    localparam logic [2:0] PG_70   = 3'd4;
    localparam logic [2:0] PG_74   = 3'd5;

    localparam logic [7:0] PFX_48 = 8'h48;
    localparam logic [7:0] PFX_60 = 8'h60;
    localparam logic [7:0] PFX_64 = 8'h64;
    localparam logic [7:0] PFX_70 = 8'h70;
    localparam logic [7:0] PFX_74 = 8'h74;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/ika87ad_prefix_detect.sv
// Classifies a fetched byte as one of the five prefixes and maps it
// to its decoder page; non-prefix bytes report page 0.
module ika87ad_prefix_detect
    import ika87ad_pkg::*;
(
    input  logic [7:0] i_BYTE,
    output logic       o_IS_PREFIX,
    output logic [2:0] o_PAGE
);

    always_comb begin
        o_IS_PREFIX = 1'b1;
        o_PAGE      = PG_MAIN;
        unique case (i_BYTE)
            PFX_48:  o_PAGE = PG_48;
            PFX_60:  o_PAGE = PG_60;
            PFX_64:  o_PAGE = PG_64;
            PFX_70:  o_PAGE = PG_70;
            PFX_74:  o_PAGE = PG_74;
            default: o_IS_PREFIX = 1'b0;
        endcase
    end

endmodule

// File: rtl/ika87ad_opfetch.sv
// Instruction register and prefix tracker: fetches opcode bytes, folds a
// prefix into a page, and injects the interrupt pseudo-opcode at boundaries.
module ika87ad_opfetch
    import ika87ad_pkg::*;
#(
    parameter logic [7:0] INT_OPCODE   = 8'h73,
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic       i_EMUCLK,
    input  logic       i_RESET,
    input  logic       i_CEN,
    input  logic       i_NEXT,
    output logic       o_FETCH_REQ,
    input  logic       i_FETCH_ACK,
    input  logic [7:0] i_FETCH_DATA,
    output logic       o_PC_INC,
    input  logic       i_INT_PEND,
    output logic       o_INT_ACK,
    output logic [7:0] o_OPCODE,
    output logic [2:0] o_OPCODE_PAGE,
    output logic       o_IR_VLD,
    output logic       o_PREFIXED
);

    state_t     r_state;
    logic [7:0] r_opcode;
    logic [2:0] r_page;
    logic       r_prefixed;
    logic       r_pc_inc;
    logic       r_int_ack;

    logic       w_is_prefix;
    logic [2:0] w_page;

    ika87ad_prefix_detect u_pfx (
        .i_BYTE      (i_FETCH_DATA),
        .o_IS_PREFIX (w_is_prefix),
        .o_PAGE      (w_page)
    );

    always_ff @(posedge i_EMUCLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_state    <= IDLE;
            r_opcode   <= RESET_OPCODE;
            r_page     <= PG_MAIN;
            r_prefixed <= 1'b0;
            r_pc_inc   <= 1'b0;
            r_int_ack  <= 1'b0;
        end else if (i_CEN) begin
            r_pc_inc  <= 1'b0;
            r_int_ack <= 1'b0;
            unique case (r_state)
                IDLE, HOLD: begin
                    if (i_NEXT) begin
                        if (i_INT_PEND) begin
                            r_opcode   <= INT_OPCODE;
                            r_page     <= PG_MAIN;
                            r_prefixed <= 1'b0;
                            r_int_ack  <= 1'b1;
                            r_state    <= HOLD;
                        end else begin
                            r_state <= FETCH1;
                        end
                    end
                end
                FETCH1: begin
                    if (i_FETCH_ACK) begin
                        r_pc_inc <= 1'b1;
                        if (w_is_prefix) begin
                            r_page     <= w_page;
                            r_prefixed <= 1'b1;
                            r_state    <= FETCH2;
                        end else begin
                            r_opcode   <= i_FETCH_DATA;
                            r_page     <= PG_MAIN;
                            r_prefixed <= 1'b0;
                            r_state    <= HOLD;
                        end
                    end
                end
                FETCH2: begin
                    // Second byte is always the raw opcode, even if it looks like a prefix
                    if (i_FETCH_ACK) begin
                        r_opcode <= i_FETCH_DATA;
                        r_pc_inc <= 1'b1;
                        r_state  <= HOLD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_FETCH_REQ   = (r_state == FETCH1) || (r_state == FETCH2);
    assign o_IR_VLD      = (r_state == HOLD);
    assign o_PC_INC      = r_pc_inc;
    assign o_INT_ACK     = r_int_ack;
    assign o_OPCODE      = r_opcode;
    assign o_OPCODE_PAGE = r_page;
    assign o_PREFIXED    = r_prefixed;

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Self-checking bench for ika87ad_opfetch: directed table, reset corner
// case, and randomized instructions against a transaction-level model.
module tb_ika87ad_opfetch;

    logic       clk;
    logic       i_RESET;
    logic       i_CEN;
    logic       i_NEXT;
    logic       o_FETCH_REQ;
    logic       i_FETCH_ACK;
    logic [7:0] i_FETCH_DATA;
    logic       o_PC_INC;
    logic       i_INT_PEND;
    logic       o_INT_ACK;
    logic [7:0] o_OPCODE;
    logic [2:0] o_OPCODE_PAGE;
    logic       o_IR_VLD;
    logic       o_PREFIXED;

    ika87ad_opfetch dut (
        .i_EMUCLK      (clk),
        .i_RESET       (i_RESET),
        .i_CEN         (i_CEN),
        .i_NEXT        (i_NEXT),
        .o_FETCH_REQ   (o_FETCH_REQ),
        .i_FETCH_ACK   (i_FETCH_ACK),
        .i_FETCH_DATA  (i_FETCH_DATA),
        .o_PC_INC      (o_PC_INC),
        .i_INT_PEND    (i_INT_PEND),
        .o_INT_ACK     (o_INT_ACK),
        .o_OPCODE      (o_OPCODE),
        .o_OPCODE_PAGE (o_OPCODE_PAGE),
        .o_IR_VLD      (o_IR_VLD),
        .o_PREFIXED    (o_PREFIXED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // results of the last do_instr run
    int r_inc, r_ack, r_req, r_lat;
    bit r_done;

    // Issue one boundary strobe and serve fetch requests like a bus unit.
    task automatic do_instr(input bit intp, input logic [7:0] b0,
                            input logic [7:0] b1, input int dly,
                            input bit cen_t);
        int bi, w;
        logic [7:0] b;
        r_inc = 0; r_ack = 0; r_req = 0; r_lat = -1; r_done = 0;
        @(negedge clk);
        i_NEXT = 1'b1; i_INT_PEND = intp; i_CEN = 1'b1;
        @(negedge clk);
        i_NEXT = 1'b0; i_INT_PEND = 1'b0;
        bi = 0; w = 0;
        for (int cyc = 0; cyc < 200 && !r_done; cyc++) begin
            i_CEN = (o_IR_VLD || !cen_t) ? 1'b1 : (cyc % 2 == 0);
            if (o_FETCH_REQ) r_req++;
            if (i_CEN && o_PC_INC) r_inc++;
            if (i_CEN && o_INT_ACK) r_ack++;
            i_FETCH_ACK = 1'b0;
            if (o_IR_VLD) begin
                r_done = 1;
                r_lat = cyc;
            end else if (o_FETCH_REQ) begin
                b = (bi == 0) ? b0 : b1;
                if (w >= dly) begin
                    i_FETCH_ACK  = 1'b1;
                    i_FETCH_DATA = i_CEN ? b : ~b;
                    if (i_CEN) begin
                        bi++;
                        w = 0;
                    end
                end else if (i_CEN) begin
                    w++;
                end
            end
            @(negedge clk);
        end
        i_FETCH_ACK = 1'b0;
        i_CEN = 1'b1;
        if (!r_done) $display("FAIL timeout: o_IR_VLD never rose");
    endtask

    // Transaction-level reference: what one instruction must produce.
    logic [7:0] PFX [5] = '{8'h48, 8'h60, 8'h64, 8'h70, 8'h74};

    task automatic model(input bit intp, input logic [7:0] b0,
                         input logic [7:0] b1, output logic [7:0] op,
                         output int pg, output int pf, output int incs,
                         output int acks, output int nbytes);
        pg = 0;
        for (int k = 0; k < 5; k++) if (b0 == PFX[k]) pg = k + 1;
        if (intp) begin
            op = 8'h73; pg = 0; pf = 0; incs = 0; acks = 1; nbytes = 0;
        end else if (pg != 0) begin
            op = b1; pf = 1; incs = 2; acks = 0; nbytes = 2;
        end else begin
            op = b0; pf = 0; incs = 1; acks = 0; nbytes = 1;
        end
    endtask

    typedef struct {
        bit         intp;
        logic [7:0] b0;
        logic [7:0] b1;
        int         dly;
        bit         cen_t;
        logic [7:0] e_op;
        int         e_pg;
        int         e_pf;
        int         e_inc;
        int         e_ack;
    } vec_t;

    vec_t vecs [8];

    task automatic check_instr(input string tag, input logic [7:0] op,
                               input int pg, input int pf, input int inc,
                               input int ack, input int lat);
        check({tag, "_done"}, int'(r_done), 1);
        check({tag, "_op"}, int'(o_OPCODE), int'(op));
        check({tag, "_pg"}, int'(o_OPCODE_PAGE), pg);
        check({tag, "_pf"}, int'(o_PREFIXED), pf);
        check({tag, "_inc"}, r_inc, inc);
        check({tag, "_ack"}, r_ack, ack);
        if (ack != 0) check({tag, "_noreq"}, r_req, 0);
        if (lat >= 0) check({tag, "_lat"}, r_lat, lat);
    endtask

    initial begin
        logic [7:0] m_op;
        int m_pg, m_pf, m_inc, m_ack, m_nb;

        vecs[0] = '{0, 8'h54, 8'h00, 0, 0, 8'h54, 0, 0, 1, 0};
        vecs[1] = '{0, 8'h60, 8'h9A, 0, 0, 8'h9A, 2, 1, 2, 0};
        vecs[2] = '{0, 8'h48, 8'h74, 0, 0, 8'h74, 1, 1, 2, 0};
        vecs[3] = '{1, 8'h11, 8'h22, 0, 0, 8'h73, 0, 0, 0, 1};
        vecs[4] = '{0, 8'hA5, 8'h00, 3, 1, 8'hA5, 0, 0, 1, 0};
        vecs[5] = '{0, 8'h70, 8'h48, 1, 0, 8'h48, 4, 1, 2, 0};
        vecs[6] = '{0, 8'h64, 8'h00, 2, 1, 8'h00, 3, 1, 2, 0};
        vecs[7] = '{0, 8'h74, 8'hFF, 0, 0, 8'hFF, 5, 1, 2, 0};

        i_RESET = 1'b1; i_CEN = 1'b1; i_NEXT = 1'b0;
        i_FETCH_ACK = 1'b0; i_FETCH_DATA = 8'h00; i_INT_PEND = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vld", int'(o_IR_VLD), 0);
        check("rst_req", int'(o_FETCH_REQ), 0);
        check("rst_op", int'(o_OPCODE), 0);
        check("rst_pg", int'(o_OPCODE_PAGE), 0);
        i_RESET = 1'b0;

        // Reset asserted in FETCH2 after a 70 prefix byte
        @(negedge clk);
        i_NEXT = 1'b1;
        @(negedge clk);
        i_NEXT = 1'b0; i_FETCH_ACK = 1'b1; i_FETCH_DATA = 8'h70;
        @(negedge clk);
        i_FETCH_ACK = 1'b0;
        check("f2_pf", int'(o_PREFIXED), 1);
        check("f2_pcinc", int'(o_PC_INC), 1);
        #2 i_RESET = 1'b1;
        #1;
        check("mid_rst_req", int'(o_FETCH_REQ), 0);
        check("mid_rst_pcinc", int'(o_PC_INC), 0);
        check("mid_rst_pf", int'(o_PREFIXED), 0);
        check("mid_rst_pg", int'(o_OPCODE_PAGE), 0);
        check("mid_rst_vld", int'(o_IR_VLD), 0);
        check("mid_rst_iack", int'(o_INT_ACK), 0);
        @(negedge clk);
        i_RESET = 1'b0; i_FETCH_ACK = 1'b1; i_FETCH_DATA = 8'h12;
        @(negedge clk);
        i_FETCH_ACK = 1'b0;
        check("late_ack_vld", int'(o_IR_VLD), 0);
        check("late_ack_pcinc", int'(o_PC_INC), 0);
        check("late_ack_op", int'(o_OPCODE), 0);
        do_instr(0, 8'h00, 8'h00, 0, 0);
        check_instr("post_rst", 8'h00, 0, 0, 1, 0, 1);

        for (int i = 0; i < 8; i++) begin
            do_instr(vecs[i].intp, vecs[i].b0, vecs[i].b1,
                     vecs[i].dly, vecs[i].cen_t);
            m_nb = vecs[i].intp ? 0 : (vecs[i].e_pf ? 2 : 1);
            check_instr($sformatf("vec%0d", i), vecs[i].e_op, vecs[i].e_pg,
                        vecs[i].e_pf, vecs[i].e_inc, vecs[i].e_ack,
                        vecs[i].cen_t ? -1 : m_nb * (vecs[i].dly + 1));
        end

        // IR holds through idle cycles with stray acks
        repeat (3) begin
            @(negedge clk);
            i_FETCH_ACK = 1'b1; i_FETCH_DATA = 8'h48;
        end
        @(negedge clk);
        i_FETCH_ACK = 1'b0;
        check("hold_vld", int'(o_IR_VLD), 1);
        check("hold_op", int'(o_OPCODE), 8'hFF);
        check("hold_pg", int'(o_OPCODE_PAGE), 5);
        check("hold_pcinc", int'(o_PC_INC), 0);

        for (int i = 0; i < 40; i++) begin
            bit intp, ct;
            logic [7:0] b0, b1;
            int dly;
            intp = ($urandom_range(3) == 0);
            b0 = ($urandom_range(1) == 0) ? PFX[$urandom_range(4)]
                                          : 8'($urandom);
            b1 = ($urandom_range(3) == 0) ? PFX[$urandom_range(4)]
                                          : 8'($urandom);
            dly = $urandom_range(3);
            ct = $urandom_range(1) == 1;
            model(intp, b0, b1, m_op, m_pg, m_pf, m_inc, m_ack, m_nb);
            do_instr(intp, b0, b1, dly, ct);
            check_instr($sformatf("rnd%0d", i), m_op, m_pg, m_pf, m_inc,
                        m_ack, ct ? -1 : m_nb * (dly + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
